seven_seg_display_ctrl: RTL and testbench

Controller that shares one registered hex-to-7-segment encoder between the board's two seven-segment digits. It accepts an 8-bit value with a load strobe and drives the upper nibble, then the lower nibble, into the shared encoder. It captures each encoded result into a per-digit segment register. It optionally blanks a leading zero, applies output polarity, and buffers one pending update while busy.

---
 rtl/seven_seg_display_ctrl.sv | 131 +++++++++++++
 tb/tb_seven_seg_display_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_ctrl.sv
// Two-digit hex display controller sharing one registered 7-segment encoder.
// Sequences the high then the low nibble through the encoder and latches each digit.
module seven_seg_display_ctrl #(
  parameter bit LEADING_ZERO_BLANK = 1'b1,
  parameter bit ACTIVE_LOW_OUT     = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_Value,
  input  logic       i_Load,
  output logic [3:0] o_Enc_Num,
  input  logic [6:0] i_Enc_Seg,
  output logic [6:0] o_Seg1,
  output logic [6:0] o_Seg2,
  output logic       o_Busy,
  output logic       o_Done
);

  typedef enum logic [2:0] {
    IDLE,
    HI_WAIT,
    HI_CAPT,
    LO_WAIT,
    LO_CAPT
  } state_t;

  localparam logic [6:0] BLANK = ACTIVE_LOW_OUT ? 7'h7F : 7'h00;

  state_t     state_q, state_d;
  logic [7:0] val_q, val_d;
  logic       pend_q, pend_d;
  logic [7:0] pval_q, pval_d;
  logic [3:0] enc_q, enc_d;
  logic [6:0] seg1_q, seg1_d;
  logic [6:0] seg2_q, seg2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [6:0] seg_pol;
  logic       blank_hi;

  assign seg_pol  = ACTIVE_LOW_OUT ? ~i_Enc_Seg : i_Enc_Seg;
  assign blank_hi = LEADING_ZERO_BLANK && (val_q[7:4] == 4'h0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    enc_d   = enc_q;
    seg1_d  = seg1_q;
    seg2_d  = seg2_q;
    done_d  = 1'b0;

    // Loads arriving mid-conversion park in a single slot, newest wins
    if (i_Load && (state_q == HI_WAIT ||
                   state_q == HI_CAPT ||
                   state_q == LO_WAIT)) begin
      pend_d = 1'b1;
      pval_d = i_Value;
    end

    unique case (state_q)
      IDLE: begin
        if (i_Load) begin
          val_d   = i_Value;
          enc_d   = i_Value[7:4];
          state_d = HI_WAIT;
        end
      end
      HI_WAIT: state_d = HI_CAPT;
      HI_CAPT: begin
        seg1_d  = blank_hi ? BLANK : seg_pol;
        enc_d   = val_q[3:0];
        state_d = LO_WAIT;
      end
      LO_WAIT: state_d = LO_CAPT;
      LO_CAPT: begin
        seg2_d = seg_pol;
        done_d = 1'b1;
        if (i_Load) begin
          val_d   = i_Value;
          enc_d   = i_Value[7:4];
          pend_d  = 1'b0;
          state_d = HI_WAIT;
        end else if (pend_q) begin
          val_d   = pval_q;
          enc_d   = pval_q[7:4];
          pend_d  = 1'b0;
          state_d = HI_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      val_q   <= 8'h00;
      pend_q  <= 1'b0;
      pval_q  <= 8'h00;
      enc_q   <= 4'h0;
      seg1_q  <= BLANK;
      seg2_q  <= BLANK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      enc_q   <= enc_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_Enc_Num = enc_q;
  assign o_Seg1    = seg1_q;
  assign o_Seg2    = seg2_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Bench for seven_seg_display_ctrl: registered encoder model per instance,
// scoreboard of expected digit pairs popped on each o_Done pulse.
module tb_seven_seg_display_ctrl;

  logic       clk;
  logic       rst_l;
  logic [7:0] value;
  logic       load;

  logic [3:0] enc_a, enc_b, enc_c;
  logic [6:0] eseg_a, eseg_b, eseg_c;
  logic [6:0] s1_a, s2_a, s1_b, s2_b, s1_c, s2_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s2;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default parameters
  seven_seg_display_ctrl u_dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Value(value), .i_Load(load),
    .o_Enc_Num(enc_a), .i_Enc_Seg(eseg_a), .o_Seg1(s1_a), .o_Seg2(s2_a),
    .o_Busy(busy_a), .o_Done(done_a)
  );

  // no leading-zero blanking
  seven_seg_display_ctrl #(.LEADING_ZERO_BLANK(1'b0)) u_nb (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Value(value), .i_Load(load),
    .o_Enc_Num(enc_b), .i_Enc_Seg(eseg_b), .o_Seg1(s1_b), .o_Seg2(s2_b),
    .o_Busy(busy_b), .o_Done(done_b)
  );

  // active-high outputs
  seven_seg_display_ctrl #(.ACTIVE_LOW_OUT(1'b0)) u_ah (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Value(value), .i_Load(load),
    .o_Enc_Num(enc_c), .i_Enc_Seg(eseg_c), .o_Seg1(s1_c), .o_Seg2(s2_c),
    .o_Busy(busy_c), .o_Done(done_c)
  );

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h7E; 4'h1: enc = 7'h30;
      4'h2: enc = 7'h6D; 4'h3: enc = 7'h79;
      4'h4: enc = 7'h33; 4'h5: enc = 7'h5B;
      4'h6: enc = 7'h5F; 4'h7: enc = 7'h70;
      4'h8: enc = 7'h7F; 4'h9: enc = 7'h7B;
      4'hA: enc = 7'h77; 4'hB: enc = 7'h1F;
      4'hC: enc = 7'h4E; 4'hD: enc = 7'h3D;
      4'hE: enc = 7'h4F; default: enc = 7'h47;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] n,
                                         input bit hi,
                                         input bit lzb,
                                         input bit alow);
    logic [6:0] s;
    s = (hi && lzb && n == 4'h0) ? 7'h00 : enc(n);
    return alow ? ~s : s;
  endfunction

  always @(posedge clk) begin
    eseg_a <= enc(enc_a);
    eseg_b <= enc(enc_b);
    eseg_c <= enc(enc_c);
  end

  // scoreboard monitor on the default instance
  always @(negedge clk) begin
    if (rst_l && done_a) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got s1=%h s2=%h, expected no done",
                 s1_a, s2_a);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (s1_a !== e.s1 || s2_a !== e.s2) begin
          errors++;
          $display("FAIL sb_digits: got s1=%h s2=%h, expected s1=%h s2=%h",
                   s1_a, s2_a, e.s1, e.s2);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] v);
    exp_t e;
    e.s1 = exp_seg(v[7:4], 1'b1, 1'b1, 1'b1);
    e.s2 = exp_seg(v[3:0], 1'b0, 1'b1, 1'b1);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    load  = 1'b0;
    value = 8'h00;
    step();
    step();
    checks++;
    if (s1_a !== 7'h7F || s2_a !== 7'h7F || busy_a !== 1'b0 ||
        done_a !== 1'b0 || enc_a !== 4'h0) begin
      errors++;
      $display("FAIL reset: got s1=%h s2=%h busy=%b done=%b enc=%h, expected 7f 7f 0 0 0",
               s1_a, s2_a, busy_a, done_a, enc_a);
    end
    checks++;
    if (s1_c !== 7'h00 || s2_c !== 7'h00) begin
      errors++;
      $display("FAIL reset_ah: got s1=%h s2=%h, expected 00 00", s1_c, s2_c);
    end
    rst_l = 1'b1;
    step();
  endtask

  task automatic test_basic();
    value = 8'h3A;
    load  = 1'b1;
    push_exp(8'h3A);
    step();
    load = 1'b0;
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy_e%0d: got %b, expected 1", e, busy_a);
      end
      if (e == 2) begin
        checks++;
        if (s1_a !== 7'h06) begin
          errors++;
          $display("FAIL basic_seg1_e2: got %h, expected 06", s1_a);
        end
      end
      checks++;
      if (done_a !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_done_e%0d: got %b, expected 0", e, done_a);
      end
      step();
    end
    checks++;
    if (done_a !== 1'b1 || s2_a !== 7'h08 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_e4: got done=%b s2=%h busy=%b, expected 1 08 0",
               done_a, s2_a, busy_a);
    end
    step();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_e5: got %b, expected 0", done_a);
    end
  endtask

  task automatic test_blank();
    value = 8'h05;
    load  = 1'b1;
    push_exp(8'h05);
    step();
    load = 1'b0;
    step();
    step();
    step();
    step();
    checks++;
    if (s1_a !== 7'h7F || s2_a !== 7'h24) begin
      errors++;
      $display("FAIL blank_def: got s1=%h s2=%h, expected 7f 24", s1_a, s2_a);
    end
    checks++;
    if (s1_b !== 7'h01) begin
      errors++;
      $display("FAIL blank_off: got s1=%h, expected 01", s1_b);
    end
    checks++;
    if (s1_c !== 7'h00 || s2_c !== 7'h5B) begin
      errors++;
      $display("FAIL blank_ah: got s1=%h s2=%h, expected 00 5b", s1_c, s2_c);
    end
    step();
  endtask

  task automatic test_values();
    logic [7:0] vals [10];
    vals = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
             8'hAB, 8'hCD, 8'hEF, 8'h00, 8'hF0};
    foreach (vals[i]) begin
      int n;
      value = vals[i];
      load  = 1'b1;
      push_exp(vals[i]);
      step();
      load = 1'b0;
      n = 0;
      while (!done_a && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (!done_a) begin
        errors++;
        $display("FAIL values_timeout %h: got no done, expected done", vals[i]);
      end
      checks++;
      if (s1_b !== exp_seg(vals[i][7:4], 1'b1, 1'b0, 1'b1) ||
          s1_c !== exp_seg(vals[i][7:4], 1'b1, 1'b1, 1'b0) ||
          s2_c !== exp_seg(vals[i][3:0], 1'b0, 1'b1, 1'b0)) begin
        errors++;
        $display("FAIL values_variants %h: got nb1=%h ah1=%h ah2=%h", vals[i],
                 s1_b, s1_c, s2_c);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = done_cnt;
    value = 8'h12;
    load  = 1'b1;
    push_exp(8'h12);
    push_exp(8'h9C);
    step();
    value = 8'hEF;
    step();
    value = 8'h9C;
    step();
    load = 1'b0;
    // edges 3..7 follow, busy already checked through edge 2 below
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_e2: got %b, expected 1", busy_a);
    end
    for (int e = 3; e < 8; e++) begin
      step();
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy_e%0d: got %b, expected 1", e, busy_a);
      end
    end
    step();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e8: got done=%b busy=%b, expected 1 0", done_a, busy_a);
    end
    step();
    step();
    checks++;
    if (done_cnt - start !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt - start);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    start = done_cnt;
    value = 8'h77;
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    value = 8'h55;
    load  = 1'b1;
    step();
    load  = 1'b0;
    rst_l = 1'b0;
    step();
    checks++;
    if (s1_a !== 7'h7F || s2_a !== 7'h7F || busy_a !== 1'b0 ||
        done_a !== 1'b0 || enc_a !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid: got s1=%h s2=%h busy=%b done=%b enc=%h, expected 7f 7f 0 0 0",
               s1_a, s2_a, busy_a, done_a, enc_a);
    end
    rst_l = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_pending_e%0d: got busy=%b, expected 0", e, busy_a);
      end
    end
    checks++;
    if (done_cnt !== start) begin
      errors++;
      $display("FAIL rst_mid_done: got %0d pulses, expected 0", done_cnt - start);
    end
  endtask

  task automatic test_restart();
    int start;
    start = done_cnt;
    value = 8'h21;
    load  = 1'b1;
    push_exp(8'h21);
    push_exp(8'h48);
    step();
    load = 1'b0;
    step();
    step();
    step();
    value = 8'h48;
    load  = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL restart_e4: got done=%b busy=%b, expected 1 1", done_a, busy_a);
    end
    for (int e = 5; e < 8; e++) begin
      step();
      checks++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL restart_e%0d: got busy=%b done=%b, expected 1 0",
                 e, busy_a, done_a);
      end
    end
    step();
    checks++;
    if (done_a !== 1'b1 || s1_a !== 7'h4C || s2_a !== 7'h00) begin
      errors++;
      $display("FAIL restart_e8: got done=%b s1=%h s2=%h, expected 1 4c 00",
               done_a, s1_a, s2_a);
    end
    step();
    checks++;
    if (done_cnt - start !== 2) begin
      errors++;
      $display("FAIL restart_done_count: got %0d, expected 2", done_cnt - start);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
